// File: rtl/msx_mouse_port_ctrl.sv
// MSX general-purpose port sequencer: joystick pass-through, or the 4-nibble
// MSX mouse protocol clocked by STR edges, built from accumulated host deltas.
module msx_mouse_port_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [5:0] joy_n,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic       stra,
    output logic [5:0] port_n,
    output logic       mouse_mode,
    output logic [1:0] phase
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] stra_sync_q;
    logic                   stra_prev_q;
    logic                   mode_q, mode_d;
    logic [1:0]             phase_q, phase_d;
    logic [7:0]             acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [7:0]             tx_x_q, tx_x_d, tx_y_q, tx_y_d;
    logic [3:0]             nibble_q, nibble_d;
    logic [TW-1:0]          timeout_q, timeout_d;
    logic [5:0]             port_q, port_d;

    logic       stra_s;
    logic       stra_edge;
    logic       edge_act;
    logic       mode_clear;
    logic [7:0] base_x, base_y;
    logic       unused_flags;

    assign stra_s       = stra_sync_q[SYNC_STAGES-1];
    assign stra_edge    = stra_s ^ stra_prev_q;
    assign edge_act     = mode_q & stra_edge;
    assign mode_clear   = ~(&joy_n) & ~mouse_strobe;
    assign unused_flags = ^mouse_flags[7:2];

    assign port_n     = port_q;
    assign mouse_mode = mode_q;
    assign phase      = phase_q;

    // Signed 10-bit intermediate clamped into the 8-bit accumulator range.
    function automatic logic [7:0] sat8(input logic [9:0] v);
        if (!v[9] && (v[8:7] != 2'b00))
            return 8'h7F;
        else if (v[9] && (v[8:7] != 2'b11))
            return 8'h80;
        else
            return v[7:0];
    endfunction

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stra_sync_q <= '0;
            stra_prev_q <= 1'b0;
            mode_q      <= 1'b0;
            phase_q     <= 2'd0;
            acc_x_q     <= 8'd0;
            acc_y_q     <= 8'd0;
            tx_x_q      <= 8'd0;
            tx_y_q      <= 8'd0;
            nibble_q    <= 4'd0;
            timeout_q   <= '0;
            port_q      <= 6'h3F;
        end else begin
            stra_sync_q <= {stra_sync_q[SYNC_STAGES-2:0], stra};
            stra_prev_q <= stra_s;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            tx_x_q      <= tx_x_d;
            tx_y_q      <= tx_y_d;
            nibble_q    <= nibble_d;
            timeout_q   <= timeout_d;
            port_q      <= port_d;
        end
    end

    // Next-state logic
    always_comb begin
        mode_d    = mode_q;
        phase_d   = phase_q;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        tx_x_d    = tx_x_q;
        tx_y_d    = tx_y_q;
        nibble_d  = nibble_q;
        timeout_d = timeout_q;
        base_x    = acc_x_q;
        base_y    = acc_y_q;

        if (mode_clear) begin
            mode_d    = 1'b0;
            phase_d   = 2'd0;
            acc_x_d   = 8'd0;
            acc_y_d   = 8'd0;
            timeout_d = '0;
        end else begin
            if (mouse_strobe)
                mode_d = 1'b1;

            if (edge_act) begin
                timeout_d = TIMEOUT_LOAD;
                phase_d   = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        // A delta arriving on the snapshot edge lands on the cleared value.
                        tx_x_d   = acc_x_q;
                        tx_y_d   = acc_y_q;
                        acc_x_d  = 8'd0;
                        acc_y_d  = 8'd0;
                        base_x   = 8'd0;
                        base_y   = 8'd0;
                        nibble_d = acc_x_q[7:4];
                    end
                    2'd1:    nibble_d = tx_x_q[3:0];
                    2'd2:    nibble_d = tx_y_q[7:4];
                    default: nibble_d = tx_y_q[3:0];
                endcase
            end else if (timeout_q != '0) begin
                timeout_d = timeout_q - TW'(1);
                if (timeout_q == TW'(1))
                    phase_d = 2'd0;
            end

            if (mouse_strobe) begin
                acc_x_d = sat8({{2{base_x[7]}}, base_x} - {mouse_x[8], mouse_x});
                acc_y_d = sat8({{2{base_y[7]}}, base_y} + {mouse_y[8], mouse_y});
            end
        end
    end

    // Output logic
    always_comb begin
        port_d = 6'h3F;
        if (mode_d)
            port_d = {~mouse_flags[1:0], nibble_d};
        else if (!stra_s)
            port_d = joy_n;
    end

endmodule

// File: tb/tb_msx_mouse_port_ctrl.sv
// Bench for msx_mouse_port_ctrl: directed test-plan steps plus random traffic,
// all checked every cycle against a cycle-count based behavioural model.
module tb_msx_mouse_port_ctrl;

    localparam int TO = 300;
    localparam int SS = 2;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] joy_n = 6'h3F;
    logic [8:0] mouse_x = '0;
    logic [8:0] mouse_y = '0;
    logic [7:0] mouse_flags = '0;
    logic       mouse_strobe = 1'b0;
    logic       stra = 1'b0;
    logic [5:0] port_n;
    logic       mouse_mode;
    logic [1:0] phase;

    int vectors = 0;
    int errors = 0;

    msx_mouse_port_ctrl #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
        .clk_sys(clk_sys), .reset(reset), .joy_n(joy_n),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_flags(mouse_flags),
        .mouse_strobe(mouse_strobe), .stra(stra),
        .port_n(port_n), .mouse_mode(mouse_mode), .phase(phase)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural model state
    bit         m_valid = 0;
    int         m_cycle = 0;
    bit         m_mode;
    int         m_ax, m_ay, m_tx, m_ty, m_phase, m_nib, m_last_edge;
    bit         m_hist[$];
    logic [5:0] m_port;

    function automatic int sx9(input logic [8:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input int v);
        return (v > 127) ? 127 : (v < -128) ? -128 : v;
    endfunction

    task automatic model_step();
        bit s_now, s_prev, edge_act, clr;
        int bx, by;
        m_cycle++;
        if (reset) begin
            m_valid = 1; m_mode = 0; m_ax = 0; m_ay = 0; m_tx = 0; m_ty = 0;
            m_phase = 0; m_nib = 0; m_last_edge = -1; m_port = 6'h3F;
            m_hist = {};
            for (int i = 0; i <= SS; i++) m_hist.push_back(1'b0);
        end else begin
            s_now    = m_hist[SS-1];
            s_prev   = m_hist[SS];
            edge_act = m_mode && (s_now != s_prev);
            clr      = (joy_n != 6'h3F) && !mouse_strobe;
            if (clr) begin
                m_mode = 0; m_phase = 0; m_ax = 0; m_ay = 0; m_last_edge = -1;
            end else begin
                bx = m_ax;
                by = m_ay;
                if (edge_act) begin
                    case (m_phase)
                        0: begin
                            m_tx = m_ax; m_ty = m_ay;
                            m_nib = (m_ax & 255) >> 4;
                            m_ax = 0; m_ay = 0; bx = 0; by = 0;
                        end
                        1: m_nib = m_tx & 15;
                        2: m_nib = (m_ty & 255) >> 4;
                        default: m_nib = m_ty & 15;
                    endcase
                    m_phase = (m_phase + 1) % 4;
                    m_last_edge = m_cycle;
                end else if (m_last_edge >= 0 && (m_cycle - m_last_edge) == TO) begin
                    m_phase = 0;
                    m_last_edge = -1;
                end
                if (mouse_strobe) begin
                    m_mode = 1;
                    m_ax = clamp(bx - sx9(mouse_x));
                    m_ay = clamp(by + sx9(mouse_y));
                end
            end
            m_port = m_mode ? {~mouse_flags[1:0], 4'(m_nib)} : (s_now ? 6'h3F : joy_n);
            m_hist.push_front(stra);
            void'(m_hist.pop_back());
        end
    endtask

    initial forever begin
        @(posedge clk_sys);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk_sys);
        if (m_valid) begin
            vectors++;
            if (port_n !== m_port || mouse_mode !== m_mode || phase !== 2'(m_phase)) begin
                errors++;
                $display("FAIL model t=%0t port_n=%h exp %h mode=%b exp %b phase=%0d exp %0d",
                         $time, port_n, m_port, mouse_mode, m_mode, phase, m_phase);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [8:0] x, input logic [8:0] y);
        mouse_x = x; mouse_y = y; mouse_strobe = 1'b1;
        cyc(1);
        mouse_strobe = 1'b0;
        cyc(1);
    endtask

    task automatic read_nib(input string nm, input logic [5:0] exp);
        stra = ~stra;
        cyc(3);
        check(nm, port_n, exp);
        cyc(197);
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check("reset_port", port_n, 6'h3F);
        check("reset_mode", mouse_mode, 0);
        check("reset_phase", phase, 0);

        // mode entry: x=-5, y=+3
        mouse_x = 9'h1FB; mouse_y = 9'h003; mouse_strobe = 1'b1;
        cyc(1);
        mouse_strobe = 1'b0;
        check("mode_entry", mouse_mode, 1);
        cyc(1);

        read_nib("nib_xhi", 6'h30);
        read_nib("nib_xlo", 6'h35);
        read_nib("nib_yhi", 6'h30);
        read_nib("nib_ylo", 6'h33);
        check("phase_wrap", phase, 0);

        // saturation
        repeat (3) pulse(9'h19C, 9'h000);
        repeat (5) pulse(9'h000, 9'h1C4);
        read_nib("sat_xhi", 6'h37);
        read_nib("sat_xlo", 6'h3F);
        read_nib("sat_yhi", 6'h38);
        read_nib("sat_ylo", 6'h30);

        // strobe in the same cycle as the phase-0 edge
        pulse(9'h1FC, 9'h000);
        stra = ~stra;
        cyc(2);
        mouse_x = 9'h1FE; mouse_y = 9'h000; mouse_strobe = 1'b1;
        cyc(1);
        mouse_strobe = 1'b0;
        check("simul_xhi", port_n, 6'h30);
        cyc(197);
        read_nib("simul_xlo", 6'h34);
        read_nib("simul_yhi", 6'h30);
        read_nib("simul_ylo", 6'h30);
        read_nib("next_xhi", 6'h30);
        read_nib("next_xlo", 6'h32);
        read_nib("next_yhi", 6'h30);
        read_nib("next_ylo", 6'h30);

        // timeout
        read_nib("to_xhi", 6'h30);
        read_nib("to_xlo", 6'h30);
        pulse(9'h1B0, 9'h000);
        cyc(TO + 5);
        check("timeout_phase", phase, 0);
        read_nib("timeout_fresh", 6'h35);
        check("timeout_phase1", phase, 1);

        // buttons then reset mid-transfer
        mouse_flags = 8'h01;
        cyc(1);
        check("buttons", port_n[5:4], 2'b10);
        stra = ~stra;
        cyc(3);
        check("pre_reset_phase", phase, 2);
        reset = 1'b1;
        cyc(1);
        check("midreset_port", port_n, 6'h3F);
        check("midreset_mode", mouse_mode, 0);
        check("midreset_phase", phase, 0);
        stra = 1'b0; mouse_flags = 8'h00;
        cyc(1);
        reset = 1'b0;
        cyc(4);

        // mode exit by joystick
        pulse(9'h1FB, 9'h003);
        check("reentry_mode", mouse_mode, 1);
        joy_n = 6'h3E;
        cyc(1);
        check("exit_mode", mouse_mode, 0);
        check("exit_phase", phase, 0);
        check("exit_port_lo", port_n, 6'h3E);
        stra = 1'b1;
        cyc(3);
        check("exit_port_hi", port_n, 6'h3F);
        joy_n = 6'h3F; stra = 1'b0;
        cyc(4);

        // random traffic, alternating fast and sparse STR activity
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = (seg % 2 == 1) ? 500 : 15;
            for (int c = 0; c < 1000; c++) begin
                reset = ($urandom_range(0, 2999) == 0);
                mouse_strobe = ($urandom_range(0, 7) == 0);
                mouse_x = 9'($urandom);
                mouse_y = 9'($urandom);
                if ($urandom_range(0, 15) == 0) mouse_flags = 8'($urandom);
                joy_n = ($urandom_range(0, 99) < 3) ? 6'($urandom) : 6'h3F;
                if ($urandom_range(0, rate - 1) == 0) stra = ~stra;
                cyc(1);
            end
        end
        reset = 1'b0; mouse_strobe = 1'b0; joy_n = 6'h3F;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/msx_mouse_port_ctrl.md
Name: msx_mouse_port_ctrl

Overview:
- Sequencer for one MSX general-purpose (joystick) port. Shares the port between a host-supplied joystick and the host PS/2-style mouse.
- In mouse mode it accumulates host motion deltas and serves them as the MSX 4-nibble mouse protocol, clocked by the port strobe (STR) pin driven by the PSG.
- Sits between user_io (joystick/mouse) and emsx_top pJoyA/pStra. Top-level pin reordering stays outside this block.

Parameters:
- TIMEOUT_CYCLES, 100000: clk_sys cycles without an STR edge before the protocol phase returns to 0 (about 3.5 ms at 28.375 MHz).
- SYNC_STAGES, 2: synchronizer depth for the stra input (minimum 2).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- joy_n  in  6  joystick, active-low; [3:0] directions, [5:4] triggers A/B
- mouse_x  in  9  two's-complement X delta, valid on mouse_strobe
- mouse_y  in  9  two's-complement Y delta, valid on mouse_strobe
- mouse_flags  in  8  [0] left button, [1] right button, active-high
- mouse_strobe  in  1  one-cycle pulse: new mouse packet
- stra  in  1  STR pin from MSX core, asynchronous
- port_n  out  6  open-collector pin model; 0 = pulled low, 1 = released
- mouse_mode  out  1  1 = port serving mouse protocol
- phase  out  2  current nibble index (debug)

Behaviour:
- Reset values: port_n=6'h3F, mouse_mode=0, phase=0. Accumulators acc_x/acc_y, snapshots tx_x/tx_y, timeout counter and synchronizer flops all 0.
- stra passes through SYNC_STAGES flops (stra_s). edge = stra_s XOR previous stra_s. Edges are acted on only when mouse_mode=1; the previous-value flop always tracks stra_s.
- Mode control:
  - mouse_strobe sets mouse_mode.
  - Any joy_n bit low with no mouse_strobe in the same cycle clears it. If both occur in one cycle, the strobe wins.
  - Clearing the mode forces phase=0, acc=0, timeout=0.
- Accumulation on mouse_strobe:
  - acc_x <= sat8(acc_x - mouse_x); acc_y <= sat8(acc_y + mouse_y).
  - Arithmetic is sign-extended to 10 bits, then clamped to [-128,+127].
- Protocol, on each edge in mouse mode:
  - Timeout is loaded with TIMEOUT_CYCLES; phase <= phase+1, wrapping 3->0.
  - phase 0: snapshot tx_x<=acc_x, tx_y<=acc_y and clear the accumulators; nibble <= acc_x[7:4]. A mouse_strobe in the same cycle is added to the cleared value (0 + delta), never lost and never double-counted.
  - phase 1: nibble <= tx_x[3:0]. phase 2: nibble <= tx_y[7:4]. phase 3: nibble <= tx_y[3:0].
- Timeout: when nonzero it decrements each cycle. The transition 1->0 forces phase=0, and the nibble holds its last value. An edge in the same cycle as expiry takes priority (reload and advance).
- Output, registered, updated every cycle:
  - Mouse mode: port_n[3:0]=nibble (bit3 = nibble MSB), port_n[5:4] = ~mouse_flags[1:0].
  - Joystick mode: port_n = stra_s ? 6'h3F : joy_n.
- Latency:
  - Joystick input to port_n: 1 cycle.
  - stra change to new nibble on port_n: SYNC_STAGES+1 cycles.
  - mouse_flags to port_n[5:4]: 1 cycle.
- Reset mid-transfer: everything returns to reset values. The MSX BIOS read then restarts cleanly, because the mouse is re-detected on the next strobe.

Test Plan:
- Mode entry/exit: after reset, port_n=3F. Pulse mouse_strobe with x=-5 (9'h1FB), y=+3 -> mouse_mode=1 next cycle. Then hold joy_n=6'h3E -> mouse_mode=0, phase=0, port_n=3E while stra_s=0 and 3F while stra_s=1.
- Nibble sequence: mouse_x=-5, y=+3 (acc_x=+5, acc_y=+3); toggle stra 4 times, 200 cycles apart -> port_n[3:0] = 0,5,0,3 in turn, each appearing 3 cycles after its toggle; phase wraps to 0.
- Saturation: three strobes with x=-100 -> acc_x=+127; on read, nibbles are 7,F. Five strobes with y=-60 -> tx_y=0x80.
- Simultaneous strobe at phase-0 edge: acc_x=+4, strobe x=-2 in the edge cycle -> X nibbles 0,4; the next frame reads X=+2.
- Timeout: toggle stra twice, then idle TIMEOUT_CYCLES+5 -> phase=0; the next toggle serves the X high nibble of a fresh snapshot.
- Buttons/reset: mouse_flags=2'b01 -> port_n[5:4]=2'b10 after 1 cycle. Assert reset at phase 2 -> port_n=3F, mouse_mode=0, phase=0 on the following cycle.
